// File: rtl/exhaustive_sweeper_pkg.sv
// Shared types and helpers for the exhaustive stimulus sweeper.
// Holds the FSM state encoding and the width helpers.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  // Number of input vectors for a given input width.
  function automatic int nvec(input int in_w);
    return 1 << in_w;
  endfunction

  // Dwell counter width, never below one bit.
  function automatic int cnt_w(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/exhaustive_sweeper_if.sv
// Bundle between the sweeper and the surrounding bench/wrapper.
// slave = sweeper side, master = DUT/host side.
interface exhaustive_sweeper_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1
);

  localparam int NVEC = 1 << IN_W;

  logic                   start;
  logic [OUT_W-1:0]       dut_out;
  logic [NVEC*OUT_W-1:0]  expect_tbl;
  logic [IN_W-1:0]        stim;
  logic                   sample_valid;
  logic [IN_W-1:0]        sample_idx;
  logic [NVEC*OUT_W-1:0]  cap_tbl;
  logic                   busy;
  logic                   done;
  logic [IN_W:0]          mismatch_cnt;
  logic                   fail;
  logic [IN_W-1:0]        first_fail_idx;

  modport slave (
    input  start,
    input  dut_out,
    input  expect_tbl,
    output stim,
    output sample_valid,
    output sample_idx,
    output cap_tbl,
    output busy,
    output done,
    output mismatch_cnt,
    output fail,
    output first_fail_idx
  );

  modport master (
    output start,
    output dut_out,
    output expect_tbl,
    input  stim,
    input  sample_valid,
    input  sample_idx,
    input  cap_tbl,
    input  busy,
    input  done,
    input  mismatch_cnt,
    input  fail,
    input  first_fail_idx
  );

endinterface

// File: rtl/exhaustive_sweeper_dwell_timer.sv
// Dwell timer: counts 0..DWELL-1 while enabled and wraps.
// last flags the final cycle of each dwell window.
module sweep_dwell_timer
  import sweep_pkg::*;
#(
  parameter int DWELL = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = cnt_w(DWELL);
  localparam logic [CW-1:0] TOP = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == TOP);

  // Next count: hold in clear, wrap at the end of a window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/exhaustive_sweeper.sv
// Exhaustive stimulus engine: walks every input vector, captures
// the DUT response and scores it against an expected table.
module exhaustive_sweeper
  import sweep_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1,
  parameter int DWELL = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  exhaustive_sweeper_if.slave  bus
);

  localparam int NVEC = nvec(IN_W);
  localparam int TW   = NVEC * OUT_W;
  localparam logic [IN_W-1:0] LAST_V = IN_W'(NVEC - 1);

  sweep_state_t    state_q;
  sweep_state_t    state_d;
  logic [IN_W-1:0] stim_q;
  logic [IN_W-1:0] stim_d;
  logic [TW-1:0]   cap_q;
  logic [TW-1:0]   cap_d;
  logic [IN_W:0]   mcnt_q;
  logic [IN_W:0]   mcnt_d;
  logic            fail_q;
  logic            fail_d;
  logic [IN_W-1:0] ffi_q;
  logic [IN_W-1:0] ffi_d;

  logic            t_clr;
  logic            t_en;
  logic            t_last;
  logic            sample;
  logic            hit;

  sweep_dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (t_clr),
    .en   (t_en),
    .last (t_last)
  );

  // FSM next state, vector stepping, capture and scoring.
  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cap_d   = cap_q;
    mcnt_d  = mcnt_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;
    t_clr   = 1'b1;
    t_en    = 1'b0;
    sample  = 1'b0;
    hit     = bus.dut_out !=
              bus.expect_tbl[stim_q*OUT_W +: OUT_W];
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          stim_d  = '0;
          cap_d   = '0;
          mcnt_d  = '0;
          fail_d  = 1'b0;
          ffi_d   = '0;
        end
      end
      RUN: begin
        t_clr = 1'b0;
        t_en  = 1'b1;
        if (t_last) begin
          sample = 1'b1;
          cap_d[stim_q*OUT_W +: OUT_W] = bus.dut_out;
          if (hit) begin
            mcnt_d = mcnt_q + (IN_W+1)'(1);
            if (!fail_q) begin
              fail_d = 1'b1;
              ffi_d  = stim_q;
            end
          end
          if (stim_q == LAST_V) begin
            state_d = DONE;
            stim_d  = '0;
          end else begin
            stim_d = stim_q + IN_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        stim_d  = '0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stim_q  <= '0;
      cap_q   <= '0;
      mcnt_q  <= '0;
      fail_q  <= 1'b0;
      ffi_q   <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cap_q   <= cap_d;
      mcnt_q  <= mcnt_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
    end
  end

  assign bus.stim           = stim_q;
  assign bus.sample_idx     = stim_q;
  assign bus.sample_valid   = sample;
  assign bus.cap_tbl        = cap_q;
  assign bus.busy           = (state_q == RUN);
  assign bus.done           = (state_q == DONE);
  assign bus.mismatch_cnt   = mcnt_q;
  assign bus.fail           = fail_q;
  assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_exhaustive_sweeper.sv
// Bench for exhaustive_sweeper: 3-in/1-out/DWELL=4 and
// 4-in/2-out/DWELL=1 instances with directed vectors.
module tb_exhaustive_sweeper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exhaustive_sweeper_if #(.IN_W(3), .OUT_W(1)) ifa ();
  exhaustive_sweeper_if #(.IN_W(4), .OUT_W(2)) ifb ();

  exhaustive_sweeper #(.IN_W(3), .OUT_W(1), .DWELL(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  exhaustive_sweeper #(.IN_W(4), .OUT_W(2), .DWELL(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  // 0 = majority, 1 = constant 0, 2 = constant 1
  int mode_a;
  logic maj;
  assign maj = (ifa.stim[0] & ifa.stim[1]) |
               (ifa.stim[0] & ifa.stim[2]) |
               (ifa.stim[1] & ifa.stim[2]);
  assign ifa.dut_out = (mode_a == 0) ? maj :
                       (mode_a == 1) ? 1'b0 : 1'b1;
  assign ifb.dut_out = {ifb.stim[3] ^ ifb.stim[2],
                        ifb.stim[1] & ifb.stim[0]};

  typedef struct {
    logic [7:0] expt;
    int         mode;
    bit         pulse;
    logic [7:0] cap;
    int         mcnt;
    bit         fl;
    int         ffi;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_b();
    logic [31:0] t;
    logic [3:0]  v;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      t[i*2 +: 2] = {v[3] ^ v[2], v[1] & v[0]};
    end
    return t;
  endfunction

  // Full sweep on instance A with per-cycle sequence checks.
  task automatic run_a(input string nm, input bit pulse);
    int err;
    err = 0;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    check({nm, "_clr_cap"}, ifa.cap_tbl, 0);
    check({nm, "_clr_cnt"}, ifa.mismatch_cnt, 0);
    for (int c = 0; c < 32; c++) begin
      if (ifa.stim !== 3'(c / 4)) err++;
      if (ifa.sample_idx !== 3'(c / 4)) err++;
      if (ifa.busy !== 1'b1) err++;
      if (ifa.done !== 1'b0) err++;
      if (ifa.sample_valid !== ((c % 4) == 3)) err++;
      ifa.start = pulse && (c == 5 || c == 20);
      @(posedge clk); #1;
    end
    ifa.start = 1'b0;
    check({nm, "_seq_err"}, err, 0);
    check({nm, "_done"}, ifa.done, 1);
    check({nm, "_busy"}, ifa.busy, 0);
    check({nm, "_stim0"}, ifa.stim, 0);
  endtask

  // Full sweep on instance B (DWELL=1).
  task automatic run_b(input string nm);
    int err;
    err = 0;
    ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (ifb.sample_valid !== 1'b1) err++;
      if (ifb.sample_idx !== 4'(c)) err++;
      if (ifb.busy !== 1'b1) err++;
      @(posedge clk); #1;
    end
    check({nm, "_seq_err"}, err, 0);
    check({nm, "_done"}, ifb.done, 1);
    check({nm, "_sv_low"}, ifb.sample_valid, 0);
  endtask

  initial begin
    vt[0] = '{8'hE8, 0, 1'b0, 8'hE8, 0, 1'b0, 0};
    vt[1] = '{8'hC8, 0, 1'b1, 8'hE8, 1, 1'b1, 5};
    vt[2] = '{8'hE8, 1, 1'b0, 8'h00, 4, 1'b1, 3};
    vt[3] = '{8'h00, 0, 1'b0, 8'hE8, 4, 1'b1, 3};
    vt[4] = '{8'hFF, 1, 1'b0, 8'h00, 8, 1'b1, 0};
    vt[5] = '{8'h17, 0, 1'b1, 8'hE8, 8, 1'b1, 0};

    rst = 1'b1;
    mode_a = 0;
    ifa.start = 1'b0;
    ifa.expect_tbl = 8'hE8;
    ifb.start = 1'b0;
    ifb.expect_tbl = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", ifa.busy, 0);
    check("rst_done", ifa.done, 0);
    check("rst_stim", ifa.stim, 0);
    check("rst_sv", ifa.sample_valid, 0);
    check("rst_sidx", ifa.sample_idx, 0);
    check("rst_cap", ifa.cap_tbl, 0);
    check("rst_cnt", ifa.mismatch_cnt, 0);
    check("rst_fail", ifa.fail, 0);
    check("rst_ffi", ifa.first_fail_idx, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_stay", ifa.busy, 0);

    for (int i = 0; i < 6; i++) begin
      mode_a = vt[i].mode;
      ifa.expect_tbl = vt[i].expt;
      run_a($sformatf("v%0d", i), vt[i].pulse);
      check($sformatf("v%0d_cap", i), ifa.cap_tbl, vt[i].cap);
      check($sformatf("v%0d_cnt", i),
            ifa.mismatch_cnt, vt[i].mcnt);
      check($sformatf("v%0d_fail", i), ifa.fail, vt[i].fl);
      if (vt[i].fl)
        check($sformatf("v%0d_ffi", i),
              ifa.first_fail_idx, vt[i].ffi);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_hold", i), ifa.cap_tbl, vt[i].cap);
    end

    // Abort mid-sweep with reset at clock 10.
    mode_a = 2;
    ifa.expect_tbl = 8'h00;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_cnt_pre", ifa.mismatch_cnt, 2);
    check("mid_cap_pre", ifa.cap_tbl, 8'h03);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", ifa.busy, 0);
    check("abort_stim", ifa.stim, 0);
    check("abort_cap", ifa.cap_tbl, 0);
    check("abort_cnt", ifa.mismatch_cnt, 0);
    check("abort_fail", ifa.fail, 0);
    mode_a = 0;
    ifa.expect_tbl = 8'hE8;
    run_a("clean", 1'b0);
    check("clean_cap", ifa.cap_tbl, 8'hE8);
    check("clean_cnt", ifa.mismatch_cnt, 0);

    // Reset wins over start.
    rst = 1'b1;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ifa.start = 1'b0;
    check("prio_busy", ifa.busy, 0);
    check("prio_done", ifa.done, 0);
    @(posedge clk); #1;
    check("prio_idle", ifa.busy, 0);

    // Wide instance, one vector per clock.
    ifb.expect_tbl = model_b();
    run_b("b0");
    check("b0_cap", ifb.cap_tbl, model_b());
    check("b0_cnt", ifb.mismatch_cnt, 0);
    check("b0_fail", ifb.fail, 0);
    ifb.expect_tbl = ~model_b();
    run_b("b1");
    check("b1_cap", ifb.cap_tbl, model_b());
    check("b1_cnt", ifb.mismatch_cnt, 16);
    check("b1_fail", ifb.fail, 1);
    check("b1_ffi", ifb.first_fail_idx, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exhaustive_sweeper.md
# exhaustive_sweeper

Synthesizable, parametrised exhaustive-stimulus engine for small combinational DUTs. On `start` it drives every input vector 0 .. 2^IN_W-1 in ascending order, holding each for DWELL clocks. It samples the DUT response at the end of each dwell into a captured truth table and checks it against an expected table. It reports a mismatch count, the first failing vector, and a `done` flag. It sits beside a DUT in a bench or FPGA self-test wrapper, so a timed initial-block sweep becomes a clocked, checkable block.

## Interface
- IN_W, 3: DUT input width; number of vectors NVEC = 2^IN_W (1..10).
- OUT_W, 1: DUT output width.
- DWELL, 20: clocks each vector is held (>= 1).

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- dut_out  in  OUT_W  DUT response to `stim`.
- expect_tbl  in  NVEC*OUT_W  expected response; entry i at bits [i*OUT_W +: OUT_W]; must be stable while busy.
- stim  out  IN_W  vector driven to DUT.
- sample_valid  out  1  one-cycle pulse in the cycle `dut_out` is captured.
- sample_idx  out  IN_W  vector index being captured (equals `stim`).
- cap_tbl  out  NVEC*OUT_W  captured responses, same packing as `expect_tbl`.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until `start` or `rst`.
- mismatch_cnt  out  IN_W+1  number of vectors with cap != expect.
- fail  out  1  mismatch_cnt != 0.
- first_fail_idx  out  IN_W  lowest failing index; valid when `fail`=1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: stim=0, busy=0, done=0. `start`=1 -> RUN. On entry to RUN: cap_tbl, mismatch_cnt, fail, and first_fail_idx clear; stim=0; dwell count=0.
- RUN: the dwell counter counts 0..DWELL-1. In the cycle where count==DWELL-1:
  - sample_valid=1 and dut_out is written to cap_tbl[stim].
  - If dut_out != expect_tbl[stim], mismatch_cnt is incremented.
  - On the first mismatch, first_fail_idx<=stim and fail<=1.
  - Next cycle: count=0 and stim=stim+1.
  - If stim==NVEC-1, go to DONE instead. stim never wraps within a sweep.
- DONE: busy=0, done=1, stim=0. Results are held. `start`=1 -> RUN (restart with clear).
- `start` in RUN is ignored.
- mismatch_cnt max is NVEC, which fits in IN_W+1 bits. No saturation is needed.
- Reset values: stim=0, sample_valid=0, sample_idx=0, cap_tbl=0, busy=0, done=0, mismatch_cnt=0, fail=0, first_fail_idx=0, state=IDLE.
- `rst` mid-sweep aborts the sweep. All outputs take their reset values at the next edge. `rst` has priority over `start`.

## Timing
- start sampled at edge E0. busy=1 and stim=0 from E0.
- Vector k is driven during cycles k*DWELL .. k*DWELL+DWELL-1 after E0. It is captured at the edge ending its last cycle.
- The DUT is combinational with respect to `stim`. It has DWELL-1 full cycles of settle before the sample.
- The last capture happens at edge NVEC*DWELL. done=1 and busy=0 from that edge. Total latency is NVEC*DWELL clocks.
- DWELL=1: one vector per clock, and sample_valid stays high for NVEC consecutive cycles.
- Compare and count use the same-cycle `dut_out` and `expect_tbl`. Results are registered, with no extra latency.

## Structure
- Package `sweep_pkg` contains:
  - state enum `sweep_state_t` {IDLE, RUN, DONE};
  - a helper function for NVEC;
  - the dwell counter width `$clog2(DWELL)` (minimum 1).
- Sub-module `sweep_dwell_timer`: parametrised by DWELL, with inputs clr and en and output `last` (count==DWELL-1). It is instantiated once.
- The top holds the FSM, the vector counter, the capture RAM (flat register) and the checker.

## Test plan
- IN_W=3, OUT_W=1, DWELL=4, DUT = majority(A,B,C), expect_tbl=8'hE8:
  - start -> stim steps 0..7 every 4 clocks;
  - done at clock 32, cap_tbl=8'hE8, mismatch_cnt=0, fail=0.
- Same setup with expect_tbl=8'hC8 (bit 5 cleared) -> mismatch_cnt=1, fail=1, first_fail_idx=5, cap_tbl=8'hE8.
- DUT = constant 0, expect_tbl=8'hE8 -> mismatch_cnt=4, first_fail_idx=3.
- rst asserted at clock 10 of a sweep -> next edge: busy=0, stim=0, cap_tbl=0, mismatch_cnt=0.
  - start re-asserted afterwards -> full clean sweep, done at clock 32.
- `start` pulsed at clocks 5 and 20 of a run -> ignored; done still at clock 32.
  - start in DONE -> results clear and a new sweep runs.
- IN_W=4, OUT_W=2, DWELL=1, DUT = {A^B, C&D}:
  - sample_valid high for 16 consecutive cycles, sample_idx 0..15;
  - done at clock 16;
  - cap_tbl matches the reference model bit-for-bit.
